ui_reg_rd_ctrl: RTL and testbench

//  Sequences register reads from the command parser to the two read sources (PHI, CHRG).

---
 rtl/ui_reg_rd_if.sv | 50 +++++
 rtl/ui_reg_rd_ctrl.sv | 147 ++++++++++++++
 tb/tb_ui_reg_rd_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ui_reg_rd_if.sv
// Bus bundle between the register-read controller and its neighbours:
// the command parser (request), the PHI/CHRG sources and the response generator.
interface ui_reg_rd_if #(
  parameter int PHIWIDTH = 36,
  parameter int CWIDTH   = 36,
  parameter int DATA_W   = 36,
  parameter int ADDR_W   = 16
);
  // Request side (cmd_parse)
  logic                rd_req_val;
  logic                rd_req_src;
  logic [ADDR_W-1:0]   rd_req_addr;
  logic                rd_req_rdy;

  // Source side (PHI / CHRG)
  logic                phi_rd_req;
  logic                chrg_rd_req;
  logic [ADDR_W-1:0]   src_rd_addr;
  logic                phi_rdy;
  logic [PHIWIDTH-1:0] phi_rdata;
  logic                chrg_rdy;
  logic [CWIDTH-1:0]   chrg_rdata;

  // Response side (response generator)
  logic                rd_resp_val;
  logic [DATA_W-1:0]   rd_resp_data;
  logic                rd_resp_err;
  logic                rd_resp_ack;

  // Status
  logic                spurious_rdy;

  // Environment around the controller
  modport master (
    output rd_req_val, rd_req_src, rd_req_addr,
    output phi_rdy, phi_rdata, chrg_rdy, chrg_rdata,
    output rd_resp_ack,
    input  rd_req_rdy, phi_rd_req, chrg_rd_req, src_rd_addr,
    input  rd_resp_val, rd_resp_data, rd_resp_err, spurious_rdy
  );

  // The controller itself
  modport slave (
    input  rd_req_val, rd_req_src, rd_req_addr,
    input  phi_rdy, phi_rdata, chrg_rdy, chrg_rdata,
    input  rd_resp_ack,
    output rd_req_rdy, phi_rd_req, chrg_rd_req, src_rd_addr,
    output rd_resp_val, rd_resp_data, rd_resp_err, spurious_rdy
  );
endinterface

// File: rtl/ui_reg_rd_ctrl.sv
// Register-read sequencer: accepts one read from cmd_parse, strobes the
// selected source (PHI or CHRG), waits for its rdy under a timeout, and holds
// the zero-extended result (or a timeout error) until the response is acked.
module ui_reg_rd_ctrl #(
  parameter int PHIWIDTH = 36,
  parameter int CWIDTH   = 36,
  parameter int DATA_W   = 36,
  parameter int ADDR_W   = 16,
  parameter int TIMEOUT  = 256
) (
  input  logic          clk,
  input  logic          rst,
  ui_reg_rd_if.slave    bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t              state_q,       state_d;
  logic                src_q,         src_d;          // 0 = PHI, 1 = CHRG
  logic [ADDR_W-1:0]   src_rd_addr_q, src_rd_addr_d;
  logic [CNT_W-1:0]    cnt_q,         cnt_d;
  logic                phi_rd_req_q,  phi_rd_req_d;
  logic                chrg_rd_req_q, chrg_rd_req_d;
  logic                resp_val_q,    resp_val_d;
  logic [DATA_W-1:0]   resp_data_q,   resp_data_d;
  logic                resp_err_q,    resp_err_d;
  logic                spurious_q,    spurious_d;

  logic                sel_rdy;
  logic                oth_rdy;
  logic [DATA_W-1:0]   sel_data;

  // Route the rdy/data of the source chosen for the current read
  always_comb begin
    sel_rdy  = src_q ? bus.chrg_rdy : bus.phi_rdy;
    oth_rdy  = src_q ? bus.phi_rdy  : bus.chrg_rdy;
    sel_data = src_q ? DATA_W'(bus.chrg_rdata) : DATA_W'(bus.phi_rdata);
  end

  // Next-state and next-output logic of the read sequencer
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    src_d         = src_q;
    src_rd_addr_d = src_rd_addr_q;
    cnt_d         = cnt_q;
    phi_rd_req_d  = 1'b0;
    chrg_rd_req_d = 1'b0;
    resp_val_d    = resp_val_q;
    resp_data_d   = resp_data_q;
    resp_err_d    = resp_err_q;
    spurious_d    = spurious_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.phi_rdy || bus.chrg_rdy) spurious_d = 1'b1;
        if (bus.rd_req_val) begin
          src_d         = bus.rd_req_src;
          src_rd_addr_d = bus.rd_req_addr;
          cnt_d         = '0;
          phi_rd_req_d  = ~bus.rd_req_src;
          chrg_rd_req_d = bus.rd_req_src;
          state_d       = ST_REQ;
        end
      end

      ST_REQ, ST_WAIT: begin
        if (oth_rdy) spurious_d = 1'b1;
        if (sel_rdy) begin
          // rdy on the final counted cycle still wins over the timeout
          resp_val_d  = 1'b1;
          resp_data_d = sel_data;
          resp_err_d  = 1'b0;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_val_d  = 1'b1;
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_WAIT;
        end
      end

      ST_RESP: begin
        // Any rdy here is late (e.g. after a timeout) and never touches data
        if (bus.phi_rdy || bus.chrg_rdy) spurious_d = 1'b1;
        if (bus.rd_resp_ack) begin
          resp_val_d  = 1'b0;
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q       <= ST_IDLE;
      src_q         <= 1'b0;
      src_rd_addr_q <= '0;
      cnt_q         <= '0;
      phi_rd_req_q  <= 1'b0;
      chrg_rd_req_q <= 1'b0;
      resp_val_q    <= 1'b0;
      resp_data_q   <= '0;
      resp_err_q    <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      src_rd_addr_q <= src_rd_addr_d;
      cnt_q         <= cnt_d;
      phi_rd_req_q  <= phi_rd_req_d;
      chrg_rd_req_q <= chrg_rd_req_d;
      resp_val_q    <= resp_val_d;
      resp_data_q   <= resp_data_d;
      resp_err_q    <= resp_err_d;
      spurious_q    <= spurious_d;
    end
  end

  assign bus.rd_req_rdy   = (state_q == ST_IDLE);
  assign bus.phi_rd_req   = phi_rd_req_q;
  assign bus.chrg_rd_req  = chrg_rd_req_q;
  assign bus.src_rd_addr  = src_rd_addr_q;
  assign bus.rd_resp_val  = resp_val_q;
  assign bus.rd_resp_data = resp_data_q;
  assign bus.rd_resp_err  = resp_err_q;
  assign bus.spurious_rdy = spurious_q;

endmodule

// File: tb/tb_ui_reg_rd_ctrl.sv
// Self-checking bench for ui_reg_rd_ctrl: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// transaction-level model expressed in absolute cycle numbers.
module tb_ui_reg_rd_ctrl;

  localparam int PHIWIDTH = 36;
  localparam int CWIDTH   = 20;
  localparam int DATA_W   = 36;
  localparam int ADDR_W   = 16;
  localparam int TIMEOUT  = 8;

  logic clk = 1'b0;
  logic rst;

  ui_reg_rd_if #(.PHIWIDTH(PHIWIDTH), .CWIDTH(CWIDTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ui_reg_rd_ctrl #(
    .PHIWIDTH(PHIWIDTH), .CWIDTH(CWIDTH), .DATA_W(DATA_W),
    .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A read is "in flight" from acceptance until it resolves; its strobe
  // happens in cycle m_pulse and its deadline is m_pulse + TIMEOUT - 1.
  int unsigned       cyc = 0;
  bit                m_flight, m_resp, m_src, m_err, m_spur;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int unsigned       m_pulse;

  always @(posedge clk) begin
    bit sel, oth;
    if (rst) begin
      m_flight = 0; m_resp = 0; m_src = 0; m_err = 0; m_spur = 0;
      m_addr = '0; m_data = '0;
    end else if (!m_flight && !m_resp) begin
      if (bus.phi_rdy || bus.chrg_rdy) m_spur = 1;
      if (bus.rd_req_val) begin
        m_flight = 1;
        m_src    = bus.rd_req_src;
        m_addr   = bus.rd_req_addr;
        m_pulse  = cyc + 1;
      end
    end else if (m_flight) begin
      sel = m_src ? bus.chrg_rdy : bus.phi_rdy;
      oth = m_src ? bus.phi_rdy  : bus.chrg_rdy;
      if (oth) m_spur = 1;
      if (sel) begin
        m_flight = 0; m_resp = 1; m_err = 0;
        m_data   = m_src ? DATA_W'(bus.chrg_rdata) : DATA_W'(bus.phi_rdata);
      end else if (cyc - m_pulse == TIMEOUT - 1) begin
        m_flight = 0; m_resp = 1; m_err = 1; m_data = '0;
      end
    end else begin
      if (bus.phi_rdy || bus.chrg_rdy) m_spur = 1;
      if (bus.rd_resp_ack) m_resp = 0;
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  int phi_strobes = 0;

  always @(posedge clk) begin
    bit strobe;
    #1;
    strobe = m_flight && (cyc == m_pulse);
    check("rd_req_rdy",   bus.rd_req_rdy,   !m_flight && !m_resp);
    check("phi_rd_req",   bus.phi_rd_req,   strobe && !m_src);
    check("chrg_rd_req",  bus.chrg_rd_req,  strobe && m_src);
    check("src_rd_addr",  bus.src_rd_addr,  m_addr);
    check("rd_resp_val",  bus.rd_resp_val,  m_resp);
    if (m_resp) begin
      check("rd_resp_data", bus.rd_resp_data, m_data);
      check("rd_resp_err",  bus.rd_resp_err,  m_err);
    end
    check("spurious_rdy", bus.spurious_rdy, m_spur);
    if (bus.phi_rd_req) phi_strobes++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.rd_req_val = 0; bus.rd_req_src = 0; bus.rd_req_addr = '0;
    bus.phi_rdy = 0; bus.phi_rdata = '0; bus.chrg_rdy = 0; bus.chrg_rdata = '0;
    bus.rd_resp_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    check("reset_val",  bus.rd_resp_val,  0);
    check("reset_spur", bus.spurious_rdy, 0);
    check("reset_rdy",  bus.rd_req_rdy,   1);
  endtask

  // Present a request in IDLE; returns at the negedge of the strobe cycle.
  task automatic issue(input bit src, input logic [ADDR_W-1:0] addr);
    @(negedge clk);
    bus.rd_req_val = 1; bus.rd_req_src = src; bus.rd_req_addr = addr;
    @(negedge clk);
    bus.rd_req_val = 0;
  endtask

  task automatic ack_resp();
    bus.rd_resp_ack = 1;
    @(negedge clk);
    bus.rd_resp_ack = 0;
    check("ack_val_low", bus.rd_resp_val, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    logic [DATA_W-1:0] held;
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    // Reset state
    check("rst_val",  bus.rd_resp_val,  0);
    check("rst_data", bus.rd_resp_data, 0);
    check("rst_err",  bus.rd_resp_err,  0);
    check("rst_phi",  bus.phi_rd_req,   0);
    check("rst_chrg", bus.chrg_rd_req,  0);
    check("rst_addr", bus.src_rd_addr,  0);
    check("rst_spur", bus.spurious_rdy, 0);
    check("rst_rdy",  bus.rd_req_rdy,   1);

    // 1: PHI read, rdy 3 cycles after the strobe
    issue(0, 16'h0012);
    check("t1_strobe", bus.phi_rd_req,  1);
    check("t1_addr",   bus.src_rd_addr, 16'h0012);
    repeat (3) @(negedge clk);
    check("t1_val_pre", bus.rd_resp_val, 0);
    bus.phi_rdy = 1; bus.phi_rdata = 36'hA_BCDE_F012;
    @(negedge clk);
    bus.phi_rdy = 0;
    check("t1_val",  bus.rd_resp_val,  1);
    check("t1_data", bus.rd_resp_data, 36'hABCDEF012);
    check("t1_err",  bus.rd_resp_err,  0);
    ack_resp();

    // 2: CHRG read, rdy in the strobe cycle
    base = phi_strobes;
    issue(1, 16'h0100);
    check("t2_strobe", bus.chrg_rd_req, 1);
    bus.chrg_rdy = 1; bus.chrg_rdata = 20'h5;
    @(negedge clk);
    bus.chrg_rdy = 0;
    check("t2_val",  bus.rd_resp_val,  1);
    check("t2_data", bus.rd_resp_data, 36'h5);
    check("t2_no_phi", phi_strobes - base, 0);
    ack_resp();

    // 3: timeout, then a late rdy
    issue(0, 16'h0BAD);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.rd_resp_val) begin n = i; break; end
    end
    check("t3_latency", n, TIMEOUT);
    check("t3_err",  bus.rd_resp_err,  1);
    check("t3_data", bus.rd_resp_data, 0);
    bus.phi_rdy = 1; bus.phi_rdata = 36'hF_FFFF_FFFF;
    @(negedge clk);
    bus.phi_rdy = 0;
    check("t3_spur",      bus.spurious_rdy, 1);
    check("t3_data_hold", bus.rd_resp_data, 0);
    ack_resp();

    // 4: both rdy together, PHI selected
    do_reset();
    issue(0, 16'h0004);
    bus.phi_rdy = 1; bus.phi_rdata = 36'h1; bus.chrg_rdy = 1; bus.chrg_rdata = 20'h2;
    @(negedge clk);
    bus.phi_rdy = 0; bus.chrg_rdy = 0;
    check("t4_data", bus.rd_resp_data, 36'h1);
    check("t4_spur", bus.spurious_rdy, 1);
    ack_resp();

    // 5: long-held response with a pending request
    do_reset();
    issue(1, 16'h0555);
    bus.chrg_rdy = 1; bus.chrg_rdata = 20'h6789A;
    @(negedge clk);
    bus.chrg_rdy = 0;
    held = bus.rd_resp_data;
    check("t5_data", held, 36'h6789A);
    bus.rd_req_val = 1; bus.rd_req_src = 0; bus.rd_req_addr = 16'h0AAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_val",  bus.rd_resp_val,  1);
      check("t5_hold_data", bus.rd_resp_data, 36'h6789A);
      check("t5_no_strobe", bus.phi_rd_req | bus.chrg_rd_req, 0);
    end
    bus.rd_resp_ack = 1;
    @(negedge clk);
    bus.rd_resp_ack = 0;
    check("t5_ack_val", bus.rd_resp_val, 0);
    check("t5_ack_rdy", bus.rd_req_rdy,  1);
    @(negedge clk);
    bus.rd_req_val = 0;
    check("t5_next_strobe", bus.phi_rd_req,  1);
    check("t5_next_addr",   bus.src_rd_addr, 16'h0AAA);
    bus.phi_rdy = 1; bus.phi_rdata = 36'h7;
    @(negedge clk);
    bus.phi_rdy = 0;
    check("t5_next_data", bus.rd_resp_data, 36'h7);
    ack_resp();

    // 6: reset during WAIT, then rdy in IDLE
    issue(0, 16'h0077);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("t6_val",  bus.rd_resp_val,  0);
    check("t6_phi",  bus.phi_rd_req,   0);
    check("t6_addr", bus.src_rd_addr,  0);
    check("t6_spur", bus.spurious_rdy, 0);
    check("t6_rdy",  bus.rd_req_rdy,   1);
    bus.phi_rdy = 1; bus.phi_rdata = 36'h9;
    @(negedge clk);
    bus.phi_rdy = 0;
    check("t6_spur_set", bus.spurious_rdy, 1);
    check("t6_val_idle", bus.rd_resp_val,  0);

    // Randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst             = ($urandom_range(0, 199) == 0);
      bus.rd_req_val  = $urandom_range(0, 1);
      bus.rd_req_src  = $urandom_range(0, 1);
      bus.rd_req_addr = ADDR_W'($urandom);
      bus.phi_rdy     = ($urandom_range(0, 5) == 0);
      bus.phi_rdata   = {4'($urandom), 32'($urandom)};
      bus.chrg_rdy    = ($urandom_range(0, 5) == 0);
      bus.chrg_rdata  = CWIDTH'($urandom);
      bus.rd_resp_ack = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    rst = 0;
    idle_inputs();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
